// File: rtl/deck_mem_arbiter.sv
// rtl/deck_mem_arbiter.sv - single-port deck RAM arbiter between shuffler and dealer
// Owns the next-card pointer and deck-empty status; one clock, memory enable gating.
module deck_mem_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 4,
    parameter int DECK_SIZE = 52
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_StartShuffle,
    output logic              o_ShuffleActive,
    input  logic              i_ShfReq,
    input  logic              i_ShfWe,
    input  logic [ADDR_W-1:0] i_ShfAddr,
    input  logic [DATA_W-1:0] i_ShfWData,
    input  logic              i_ShfDone,
    output logic              o_ShfGnt,
    output logic [DATA_W-1:0] o_ShfRData,
    input  logic              i_DealReq,
    output logic              o_DealAck,
    output logic [DATA_W-1:0] o_DealCard,
    output logic              o_DealErr,
    output logic              o_DeckEmpty,
    output logic              o_MemEn,
    output logic              o_MemWe,
    output logic [ADDR_W-1:0] o_MemAddr,
    output logic [DATA_W-1:0] o_MemWData,
    input  logic [DATA_W-1:0] i_MemRData
);

    typedef enum logic [2:0] {IDLE, SHUFFLE, DEAL_RD, DEAL_WAIT, DEAL_HOLD} state_t;

    localparam logic [ADDR_W-1:0] DECK_END = ADDR_W'(DECK_SIZE);

    state_t            state;
    state_t            nextState;
    logic [ADDR_W-1:0] ptr;
    logic              shuffled;
    logic              shfPend;
    logic              dealAck;
    logic              dealErr;
    logic [DATA_W-1:0] dealCard;
    logic              deckEmpty;
    logic              startShf;
    logic              endShf;
    logic              capture;
    logic              errAck;
    logic              setPend;

    assign deckEmpty       = !shuffled || (ptr == DECK_END);
    assign o_DeckEmpty     = deckEmpty;
    assign o_ShuffleActive = (state == SHUFFLE);
    assign o_ShfGnt        = (state == SHUFFLE);
    assign o_ShfRData      = i_MemRData;
    assign o_DealAck       = dealAck;
    assign o_DealErr       = dealErr;
    assign o_DealCard      = dealCard;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        startShf   = 1'b0;
        endShf     = 1'b0;
        capture    = 1'b0;
        errAck     = 1'b0;
        setPend    = 1'b0;
        o_MemEn    = 1'b0;
        o_MemWe    = 1'b0;
        o_MemAddr  = '0;
        o_MemWData = '0;
        case (state)
            IDLE: begin
                // A pending or new shuffle wins over a waiting deal request.
                if (i_StartShuffle || shfPend) begin
                    nextState = SHUFFLE;
                    startShf  = 1'b1;
                end else if (i_DealReq) begin
                    if (!deckEmpty) begin
                        nextState = DEAL_RD;
                    end else begin
                        nextState = DEAL_HOLD;
                        errAck    = 1'b1;
                    end
                end
            end
            SHUFFLE: begin
                o_MemEn    = i_ShfReq;
                o_MemWe    = i_ShfReq & i_ShfWe;
                o_MemAddr  = i_ShfAddr;
                o_MemWData = i_ShfWData;
                if (i_ShfDone) begin
                    nextState = IDLE;
                    endShf    = 1'b1;
                end
            end
            DEAL_RD: begin
                o_MemEn   = 1'b1;
                o_MemAddr = ptr;
                setPend   = i_StartShuffle;
                nextState = DEAL_WAIT;
            end
            DEAL_WAIT: begin
                capture   = 1'b1;
                setPend   = i_StartShuffle;
                nextState = DEAL_HOLD;
            end
            DEAL_HOLD: begin
                // Wait for the request to drop so a held request deals only once.
                setPend = i_StartShuffle;
                if (!i_DealReq) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            ptr      <= '0;
            shuffled <= 1'b0;
            shfPend  <= 1'b0;
            dealAck  <= 1'b0;
            dealErr  <= 1'b0;
            dealCard <= '0;
        end else begin
            dealAck <= capture | errAck;
            dealErr <= errAck;
            if (capture) begin
                dealCard <= i_MemRData;
                ptr      <= ptr + ADDR_W'(1);
            end
            if (errAck) begin
                dealCard <= '0;
            end
            if (setPend) begin
                shfPend <= 1'b1;
            end
            if (startShf) begin
                ptr      <= '0;
                shuffled <= 1'b0;
                shfPend  <= 1'b0;
            end
            if (endShf) begin
                shuffled <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_deck_mem_arbiter.sv
// tb/tb_deck_mem_arbiter.sv - directed self-checking bench for deck_mem_arbiter
module tb_deck_mem_arbiter;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 4;
    localparam int DECK_SIZE = 52;

    logic              i_Clk = 1'b0;
    logic              i_Rst_n;
    logic              i_StartShuffle;
    logic              o_ShuffleActive;
    logic              i_ShfReq;
    logic              i_ShfWe;
    logic [ADDR_W-1:0] i_ShfAddr;
    logic [DATA_W-1:0] i_ShfWData;
    logic              i_ShfDone;
    logic              o_ShfGnt;
    logic [DATA_W-1:0] o_ShfRData;
    logic              i_DealReq;
    logic              o_DealAck;
    logic [DATA_W-1:0] o_DealCard;
    logic              o_DealErr;
    logic              o_DeckEmpty;
    logic              o_MemEn;
    logic              o_MemWe;
    logic [ADDR_W-1:0] o_MemAddr;
    logic [DATA_W-1:0] o_MemWData;
    logic [DATA_W-1:0] ramRData;

    logic [DATA_W-1:0] ram    [64];
    logic [DATA_W-1:0] refMem [64];

    int nCmp = 0;
    int nBad = 0;

    typedef struct {
        logic              req;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic              expEn;
        logic              expWe;
        logic [ADDR_W-1:0] expAddr;
        logic [DATA_W-1:0] expWd;
        logic              chkRd;
        logic [DATA_W-1:0] expRd;
    } vec_t;

    vec_t vecs [5];

    deck_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DECK_SIZE(DECK_SIZE)) dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_StartShuffle(i_StartShuffle),
        .o_ShuffleActive(o_ShuffleActive), .i_ShfReq(i_ShfReq), .i_ShfWe(i_ShfWe),
        .i_ShfAddr(i_ShfAddr), .i_ShfWData(i_ShfWData), .i_ShfDone(i_ShfDone),
        .o_ShfGnt(o_ShfGnt), .o_ShfRData(o_ShfRData), .i_DealReq(i_DealReq),
        .o_DealAck(o_DealAck), .o_DealCard(o_DealCard), .o_DealErr(o_DealErr),
        .o_DeckEmpty(o_DeckEmpty), .o_MemEn(o_MemEn), .o_MemWe(o_MemWe),
        .o_MemAddr(o_MemAddr), .o_MemWData(o_MemWData), .i_MemRData(ramRData)
    );

    always #5 i_Clk = ~i_Clk;

    // Synchronous single-port deck RAM
    always @(posedge i_Clk) begin
        if (o_MemEn) begin
            if (o_MemWe) ram[o_MemAddr] <= o_MemWData;
            ramRData <= ram[o_MemAddr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyTable(input logic inShuffle);
        for (int i = 0; i < 5; i++) begin
            i_ShfReq   = vecs[i].req;
            i_ShfWe    = vecs[i].we;
            i_ShfAddr  = vecs[i].addr;
            i_ShfWData = vecs[i].wd;
            @(negedge i_Clk);
            chk("tbl_gnt", o_ShfGnt, inShuffle);
            chk("tbl_en", o_MemEn, inShuffle ? vecs[i].expEn : 1'b0);
            chk("tbl_we", o_MemWe, inShuffle ? vecs[i].expWe : 1'b0);
            chk("tbl_addr", o_MemAddr, inShuffle ? vecs[i].expAddr : 6'd0);
            chk("tbl_wdata", o_MemWData, inShuffle ? vecs[i].expWd : 4'd0);
            @(posedge i_Clk); #1;
            if (inShuffle && vecs[i].chkRd) chk("tbl_rdata", o_ShfRData, vecs[i].expRd);
        end
        i_ShfReq = 1'b0; i_ShfWe = 1'b0; i_ShfAddr = '0; i_ShfWData = '0;
    endtask

    task automatic startShuffle();
        i_StartShuffle = 1'b1;
        @(posedge i_Clk); #1;
        i_StartShuffle = 1'b0;
        chk("shf_active", o_ShuffleActive, 1'b1);
        chk("shf_gnt", o_ShfGnt, 1'b1);
        chk("shf_empty", o_DeckEmpty, 1'b1);
    endtask

    task automatic endShuffle();
        i_ShfDone = 1'b1;
        @(posedge i_Clk); #1;
        i_ShfDone = 1'b0;
        chk("done_active", o_ShuffleActive, 1'b0);
        chk("done_empty", o_DeckEmpty, 1'b0);
    endtask

    task automatic dealOne(input logic [DATA_W-1:0] expCard, input logic expErr, input int expLat);
        int   n;
        logic got;
        n = 0; got = 1'b0;
        i_DealReq = 1'b1;
        while (!got && n < 20) begin
            @(posedge i_Clk); #1;
            n++;
            chk("deal_no_write", {o_MemWe, o_ShfGnt}, 2'b00);
            if (o_DealAck) got = 1'b1;
        end
        chk("deal_ack_seen", got, 1'b1);
        chk("deal_latency", n, expLat);
        chk("deal_card", o_DealCard, expCard);
        chk("deal_err", o_DealErr, expErr);
        i_DealReq = 1'b0;
        @(posedge i_Clk); #1;
        chk("deal_ack_width", o_DealAck, 1'b0);
        chk("deal_card_hold", o_DealCard, expCard);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) begin
            ram[i]    = DATA_W'((i % 13) + 1);
            refMem[i] = DATA_W'((i % 13) + 1);
        end
        ramRData = '0;
        vecs[0] = '{1'b1, 1'b1, 6'd5,  4'hA, 1'b1, 1'b1, 6'd5,  4'hA, 1'b0, 4'h0};
        vecs[1] = '{1'b1, 1'b0, 6'd5,  4'h3, 1'b1, 1'b0, 6'd5,  4'h3, 1'b1, 4'hA};
        vecs[2] = '{1'b0, 1'b1, 6'd9,  4'h7, 1'b0, 1'b0, 6'd9,  4'h7, 1'b0, 4'h0};
        vecs[3] = '{1'b1, 1'b1, 6'd60, 4'hF, 1'b1, 1'b1, 6'd60, 4'hF, 1'b0, 4'h0};
        vecs[4] = '{1'b1, 1'b0, 6'd60, 4'h0, 1'b1, 1'b0, 6'd60, 4'h0, 1'b1, 4'hF};

        i_Rst_n = 1'b0; i_StartShuffle = 1'b0; i_ShfReq = 1'b0; i_ShfWe = 1'b0;
        i_ShfAddr = '0; i_ShfWData = '0; i_ShfDone = 1'b0; i_DealReq = 1'b0;
        repeat (2) @(posedge i_Clk);
        @(negedge i_Clk);
        chk("rst_active", {o_ShuffleActive, o_ShfGnt}, 2'b00);
        chk("rst_deal", {o_DealAck, o_DealErr, o_DealCard}, 6'd0);
        chk("rst_empty", o_DeckEmpty, 1'b1);
        chk("rst_mem", {o_MemEn, o_MemWe, o_MemAddr, o_MemWData}, 12'd0);
        chk("rst_rdata", o_ShfRData, 4'd0);
        @(posedge i_Clk); #1;
        i_Rst_n = 1'b1;

        applyTable(1'b0);
        dealOne(4'd0, 1'b1, 1);

        startShuffle();
        applyTable(1'b1);
        refMem[5]  = 4'hA;
        refMem[60] = 4'hF;
        endShuffle();

        for (int d = 0; d < DECK_SIZE; d++) begin
            if (d == 1) begin
                i_ShfReq = 1'b1; i_ShfWe = 1'b1; i_ShfAddr = 6'd3; i_ShfWData = 4'hF;
            end
            if (d == 3) begin
                i_ShfReq = 1'b0; i_ShfWe = 1'b0; i_ShfAddr = '0; i_ShfWData = '0;
            end
            if (d == DECK_SIZE - 1) chk("not_empty_before_last", o_DeckEmpty, 1'b0);
            dealOne(refMem[d], 1'b0, 3);
        end
        chk("empty_after_52", o_DeckEmpty, 1'b1);
        dealOne(4'd0, 1'b1, 1);

        // Shuffle start and deal request together: shuffle first, deal after done.
        i_StartShuffle = 1'b1; i_DealReq = 1'b1;
        @(posedge i_Clk); #1;
        i_StartShuffle = 1'b0;
        chk("sim_active", o_ShuffleActive, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(posedge i_Clk); #1;
            chk("sim_no_ack", o_DealAck, 1'b0);
        end
        endShuffle();
        n = 0;
        while (!o_DealAck && n < 20) begin
            @(posedge i_Clk); #1;
            n++;
        end
        chk("sim_latency", n, 3);
        chk("sim_card", o_DealCard, refMem[0]);
        chk("sim_err", o_DealErr, 1'b0);
        i_DealReq = 1'b0;
        @(posedge i_Clk); #1;

        // Shuffle start during DEAL_WAIT is deferred until the deal completes.
        i_DealReq = 1'b1;
        @(posedge i_Clk); #1;
        @(posedge i_Clk); #1;
        i_StartShuffle = 1'b1;
        @(posedge i_Clk); #1;
        i_StartShuffle = 1'b0;
        chk("pend_ack", o_DealAck, 1'b1);
        chk("pend_card", o_DealCard, refMem[1]);
        chk("pend_not_active", o_ShuffleActive, 1'b0);
        i_DealReq = 1'b0;
        @(posedge i_Clk); #1;
        chk("pend_idle", {o_ShuffleActive, o_DealAck}, 2'b00);
        @(posedge i_Clk); #1;
        chk("pend_shuffle", o_ShuffleActive, 1'b1);
        chk("pend_empty", o_DeckEmpty, 1'b1);
        endShuffle();

        // Reset in the middle of a shuffle write burst.
        startShuffle();
        i_ShfReq = 1'b1; i_ShfWe = 1'b1; i_ShfAddr = 6'd62; i_ShfWData = 4'h9;
        @(negedge i_Clk);
        chk("rstmid_we_before", o_MemWe, 1'b1);
        #2 i_Rst_n = 1'b0;
        #1;
        chk("rstmid_mem", {o_MemEn, o_MemWe, o_ShfGnt, o_ShuffleActive}, 4'd0);
        chk("rstmid_empty", o_DeckEmpty, 1'b1);
        chk("rstmid_ack", o_DealAck, 1'b0);
        repeat (2) @(posedge i_Clk);
        #1 i_Rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge i_Clk); #1;
            chk("rstmid_no_write", {o_MemWe, o_ShfGnt}, 2'b00);
        end
        chk("rstmid_ram", ram[62], refMem[62]);
        chk("rstmid_empty_after", o_DeckEmpty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
